// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and constants for the VGA raster / scaler slice.
//                rgb24_t      - packed {r,g,b} colour word
//                vga_timing_t - one set of horizontal/vertical raster timings
//                vid_ctl_t    - per-pixel control bits carried down the
//                               fetch-latency delay line
//                VGA_640x480_60 - standard 640x480 @ 60 Hz timing
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] v_active;
        logic [11:0] v_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
    } vga_timing_t;

    typedef struct packed {
        logic pix_valid;
        logic active;
        logic hs;
        logic vs;
    } vid_ctl_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33
    };

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_gen
//  Description : Pixel-tick divider and raster counters.
//                CLOCK_50      in   system clock
//                reset         in   asynchronous, active-high
//                o_tick        out  one-cycle pixel-tick strobe
//                o_hc / o_vc   out  current column / line of the raster
//                o_active      out  current position lies in the active area
//                o_hs / o_vs   out  sync level for the current position
//                o_frame_start out  pulse on the tick that processes (0,0)
//                o_vga_clk     out  registered pixel clock for the DAC
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    output logic            o_tick,
    output logic [HC_W-1:0] o_hc,
    output logic [VC_W-1:0] o_vc,
    output logic            o_active,
    output logic            o_hs,
    output logic            o_vs,
    output logic            o_frame_start,
    output logic            o_vga_clk
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = V_ACTIVE + V_FP + V_SYNC;
    localparam int c_div_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic [HC_W-1:0]    c_h_last   = HC_W'(c_h_total - 1);
    localparam logic [VC_W-1:0]    c_v_last   = VC_W'(c_v_total - 1);

    logic [c_div_w-1:0] r_div;
    logic [HC_W-1:0]    r_hc;
    logic [VC_W-1:0]    r_vc;
    logic               r_vga_clk;
    logic               w_tick;
    int                 w_hc_i;
    int                 w_vc_i;

    assign w_tick = (r_div == c_div_last);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_hc      <= '0;
            r_vc      <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            // High for the second half of each divider period: 50% duty.
            r_vga_clk <= (r_div >= c_div_half);
            if (w_tick) begin
                r_div <= '0;
                if (r_hc == c_h_last) begin
                    r_hc <= '0;
                    r_vc <= (r_vc == c_v_last) ? '0 : r_vc + 1'b1;
                end else begin
                    r_hc <= r_hc + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Signed compares keep the window tests free of constant-unsigned cases.
    always_comb begin
        w_hc_i   = int'(r_hc);
        w_vc_i   = int'(r_vc);
        o_active = (w_hc_i < H_ACTIVE) && (w_vc_i < V_ACTIVE);
        o_hs     = ((w_hc_i >= c_hs_start) && (w_hc_i < c_hs_end)) ? HS_POL : ~HS_POL;
        o_vs     = ((w_vc_i >= c_vs_start) && (w_vc_i < c_vs_end)) ? VS_POL : ~VS_POL;
    end

    assign o_tick        = w_tick;
    assign o_hc          = r_hc;
    assign o_vc          = r_vc;
    assign o_frame_start = w_tick && (r_hc == '0) && (r_vc == '0);
    assign o_vga_clk     = r_vga_clk;

endmodule
`default_nettype wire

// File: rtl/video_scaler_timing.sv
`default_nettype none
// ============================================================================
//  Module      : video_scaler_timing
//  Description : Parametrised VGA raster generator with integer pixel scaler.
//                Centres a WIDTH x HEIGHT game frame, scaled by the largest
//                integer factor that fits, and draws BORDER_RGB around it.
//                CLOCK_50     in   system clock
//                reset        in   asynchronous, active-high
//                x, y         out  game-space pixel request
//                pix_valid    out  x/y address a visible game pixel
//                frame_start  out  one-cycle pulse at raster (0,0)
//                r, g, b      in   colour for the request PIPE_LAT ticks ago
//                VGA_*        out  DAC colour and control
//  Revision    : 1.0 - initial release
// ============================================================================
module video_scaler_timing
    import video_pkg::*;
#(
    parameter int          H_ACTIVE   = int'(VGA_640x480_60.h_active),
    parameter int          H_FP       = int'(VGA_640x480_60.h_fp),
    parameter int          H_SYNC     = int'(VGA_640x480_60.h_sync),
    parameter int          H_BP       = int'(VGA_640x480_60.h_bp),
    parameter int          V_ACTIVE   = int'(VGA_640x480_60.v_active),
    parameter int          V_FP       = int'(VGA_640x480_60.v_fp),
    parameter int          V_SYNC     = int'(VGA_640x480_60.v_sync),
    parameter int          V_BP       = int'(VGA_640x480_60.v_bp),
    parameter int          CLK_DIV    = 2,
    parameter int          WIDTH      = 160,
    parameter int          HEIGHT     = 120,
    parameter int          PIPE_LAT   = 1,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter logic [23:0] BORDER_RGB = 24'h0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       pix_valid,
    output logic       frame_start,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hc_w    = $clog2(c_h_total);
    localparam int c_vc_w    = $clog2(c_v_total);
    localparam int c_block   = min_int(H_ACTIVE / WIDTH, V_ACTIVE / HEIGHT);
    localparam int c_x_start = (H_ACTIVE - WIDTH * c_block) / 2;
    localparam int c_x_last  = c_x_start + WIDTH * c_block - 1;
    localparam int c_y_start = (V_ACTIVE - HEIGHT * c_block) / 2;
    localparam int c_y_last  = c_y_start + HEIGHT * c_block - 1;
    localparam int c_bd_w    = (c_block > 2) ? $clog2(c_block) : 1;

    localparam logic [c_bd_w-1:0] c_bd_last  = c_bd_w'(c_block - 1);
    localparam vid_ctl_t          c_ctl_idle = '{pix_valid: 1'b0, active: 1'b0,
                                                 hs: ~HS_POL, vs: ~VS_POL};

    if (c_block == 0) begin : g_err_block
        $error("video_scaler_timing: game frame larger than active area");
    end
    if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_err_div
        $error("video_scaler_timing: CLK_DIV must be even and >= 2");
    end
    if ((PIPE_LAT < 0) || (PIPE_LAT > 4)) begin : g_err_lat
        $error("video_scaler_timing: PIPE_LAT must be 0..4");
    end

    logic              w_tick;
    logic [c_hc_w-1:0] w_hc;
    logic [c_vc_w-1:0] w_vc;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;

    video_sync_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CLK_DIV  (CLK_DIV),  .HS_POL (HS_POL), .VS_POL (VS_POL),
        .HC_W     (c_hc_w),   .VC_W (c_vc_w)
    ) u_sync (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .o_tick        (w_tick),
        .o_hc          (w_hc),
        .o_vc          (w_vc),
        .o_active      (w_active),
        .o_hs          (w_hs),
        .o_vs          (w_vs),
        .o_frame_start (frame_start),
        .o_vga_clk     (VGA_CLK)
    );

    // ---------------------------------------------------------------- scaler
    // Sub-counters track the game coordinate of the current raster position
    // without a divider: xd/yd count replicas of one game pixel.
    logic              w_h_in;
    logic              w_v_in;
    logic              w_x_adv;
    logic              w_y_adv;
    logic              w_line_end;
    logic [c_bd_w-1:0] r_xd;
    logic [c_bd_w-1:0] r_yd;
    logic [9:0]        r_xc;
    logic [8:0]        r_yc;

    always_comb begin
        w_h_in     = (int'(w_hc) >= c_x_start) && (int'(w_hc) <= c_x_last);
        w_v_in     = (int'(w_vc) >= c_y_start) && (int'(w_vc) <= c_y_last);
        // Counting stops on the last window position so the counter is
        // already back at zero when the window is next entered.
        w_x_adv    = w_h_in && (int'(w_hc) != c_x_last);
        w_y_adv    = w_v_in && (int'(w_vc) != c_y_last);
        w_line_end = (int'(w_hc) == c_h_total - 1);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_xd <= '0;
            r_xc <= '0;
            r_yd <= '0;
            r_yc <= '0;
        end else if (w_tick) begin
            if (w_x_adv) begin
                if (r_xd == c_bd_last) begin
                    r_xd <= '0;
                    r_xc <= r_xc + 10'd1;
                end else begin
                    r_xd <= r_xd + 1'b1;
                end
            end else begin
                r_xd <= '0;
                r_xc <= '0;
            end
            if (w_line_end) begin
                if (w_y_adv) begin
                    if (r_yd == c_bd_last) begin
                        r_yd <= '0;
                        r_yc <= r_yc + 9'd1;
                    end else begin
                        r_yd <= r_yd + 1'b1;
                    end
                end else begin
                    r_yd <= '0;
                    r_yc <= '0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 0
    logic [9:0] r_x;
    logic [8:0] r_y;
    vid_ctl_t   r_s0;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_s0 <= c_ctl_idle;
        end else if (w_tick) begin
            r_x  <= r_xc;
            r_y  <= r_yc;
            r_s0 <= '{pix_valid: w_h_in && w_v_in, active: w_active,
                      hs: w_hs, vs: w_vs};
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign pix_valid = r_s0.pix_valid;

    // ------------------------------------------------------------ delay line
    // Matches the colour source's fetch latency so control and colour meet.
    vid_ctl_t w_ctl_d;

    if (PIPE_LAT <= 0) begin : g_no_dly
        assign w_ctl_d = r_s0;
    end else begin : g_dly
        vid_ctl_t r_dly [PIPE_LAT];

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    r_dly[i] <= c_ctl_idle;
                end
            end else if (w_tick) begin
                r_dly[0] <= r_s0;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign w_ctl_d = r_dly[PIPE_LAT-1];
    end

    // ---------------------------------------------------------- output stage
    rgb24_t r_rgb;
    logic   r_blank_n;
    logic   r_hs;
    logic   r_vs;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_rgb     <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
        end else if (w_tick) begin
            if (w_ctl_d.pix_valid) begin
                r_rgb <= {r, g, b};
            end else if (w_ctl_d.active) begin
                r_rgb <= BORDER_RGB;
            end else begin
                r_rgb <= '0;
            end
            r_blank_n <= w_ctl_d.active;
            r_hs      <= w_ctl_d.hs;
            r_vs      <= w_ctl_d.vs;
        end
    end

    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_SYNC_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_video_scaler_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_scaler_timing
//  Description : Self-checking bench for video_scaler_timing. Three instances:
//                0 - reduced raster, CLK_DIV 2, PIPE_LAT 1, window fills width
//                1 - reduced raster, CLK_DIV 4, PIPE_LAT 3, centred window,
//                    active-high HS, non-zero border
//                2 - default 640x480 parameters
//                A random-seeded image is served with the configured latency
//                and every output is compared each cycle against a model that
//                derives the expected raster position from elapsed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_scaler_timing;

    typedef struct {
        int          d, l;
        int          ha, hf, hs, hb, va, vf, vs, vb;
        int          w, h;
        bit          hpol, vpol;
        logic [23:0] border;
    } cfg_t;

    typedef struct {
        int          x, y;
        bit          pv, act, hs, vs;
        logic [23:0] rgb;
    } pix_t;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        pv, fs, vclk, hs, vs, bn;
        logic [23:0] rgb;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    int          m        = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] seed     = 32'h0;

    logic [9:0]  xo  [3];
    logic [8:0]  yo  [3];
    logic        pvo [3];
    logic        fso [3];
    logic [7:0]  ri  [3];
    logic [7:0]  gi  [3];
    logic [7:0]  bi  [3];
    logic [7:0]  vro [3];
    logic [7:0]  vgo [3];
    logic [7:0]  vbo [3];
    logic        hso [3];
    logic        vso [3];
    logic        bno [3];
    logic        sno [3];
    logic        vco [3];
    logic [23:0] pipe [3][4];

    always #5 CLOCK_50 = ~CLOCK_50;

    // Count of CLOCK_50 rising edges since reset was released.
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) m <= 0;
        else       m <= m + 1;
    end

    // ------------------------------------------------------------ instances
    video_scaler_timing #(
        .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (30), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .CLK_DIV (2), .WIDTH (10), .HEIGHT (6), .PIPE_LAT (1),
        .HS_POL (1'b0), .VS_POL (1'b0), .BORDER_RGB (24'h123456)
    ) dut0 (
        .CLOCK_50 (CLOCK_50), .reset (reset),
        .x (xo[0]), .y (yo[0]), .pix_valid (pvo[0]), .frame_start (fso[0]),
        .r (ri[0]), .g (gi[0]), .b (bi[0]),
        .VGA_R (vro[0]), .VGA_G (vgo[0]), .VGA_B (vbo[0]),
        .VGA_HS (hso[0]), .VGA_VS (vso[0]), .VGA_BLANK_N (bno[0]),
        .VGA_SYNC_N (sno[0]), .VGA_CLK (vco[0])
    );

    video_scaler_timing #(
        .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (30), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .CLK_DIV (4), .WIDTH (12), .HEIGHT (7), .PIPE_LAT (3),
        .HS_POL (1'b1), .VS_POL (1'b0), .BORDER_RGB (24'hA5C33C)
    ) dut1 (
        .CLOCK_50 (CLOCK_50), .reset (reset),
        .x (xo[1]), .y (yo[1]), .pix_valid (pvo[1]), .frame_start (fso[1]),
        .r (ri[1]), .g (gi[1]), .b (bi[1]),
        .VGA_R (vro[1]), .VGA_G (vgo[1]), .VGA_B (vbo[1]),
        .VGA_HS (hso[1]), .VGA_VS (vso[1]), .VGA_BLANK_N (bno[1]),
        .VGA_SYNC_N (sno[1]), .VGA_CLK (vco[1])
    );

    video_scaler_timing dut2 (
        .CLOCK_50 (CLOCK_50), .reset (reset),
        .x (xo[2]), .y (yo[2]), .pix_valid (pvo[2]), .frame_start (fso[2]),
        .r (ri[2]), .g (gi[2]), .b (bi[2]),
        .VGA_R (vro[2]), .VGA_G (vgo[2]), .VGA_B (vbo[2]),
        .VGA_HS (hso[2]), .VGA_VS (vso[2]), .VGA_BLANK_N (bno[2]),
        .VGA_SYNC_N (sno[2]), .VGA_CLK (vco[2])
    );

    // --------------------------------------------------------------- model
    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        c.ha = 40; c.hf = 4;  c.hs = 6; c.hb = 6;
        c.va = 30; c.vf = 2;  c.vs = 2; c.vb = 3;
        c.d  = 2;  c.l  = 1;  c.w  = 10; c.h = 6;
        c.hpol = 1'b0; c.vpol = 1'b0; c.border = 24'h123456;
        if (i == 1) begin
            c.d = 4; c.l = 3; c.w = 12; c.h = 7;
            c.hpol = 1'b1; c.border = 24'hA5C33C;
        end else if (i == 2) begin
            c.ha = 640; c.hf = 16; c.hs = 96; c.hb = 48;
            c.va = 480; c.vf = 10; c.vs = 2;  c.vb = 33;
            c.w = 160; c.h = 120; c.border = 24'h0;
        end
        return c;
    endfunction

    // Random-seeded test image: colour the source returns for game pixel (x,y).
    function automatic logic [23:0] img(input int xx, input int yy);
        logic [31:0] hv;
        hv = (32'(xx) * 32'h9E3779B1) ^ (32'(yy) * 32'h7F4A7C15) ^ seed;
        hv = hv ^ (hv >> 13);
        return hv[23:0];
    endfunction

    // What the raster shows at pixel-tick number p after reset.
    function automatic pix_t pix(input cfg_t c, input int p);
        pix_t q;
        int   ht, vt, hc, vc, blk, xs, ys;
        bit   inh, inv;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        hc    = p % ht;
        vc    = (p / ht) % vt;
        blk   = (c.ha / c.w < c.va / c.h) ? c.ha / c.w : c.va / c.h;
        xs    = (c.ha - c.w * blk) / 2;
        ys    = (c.va - c.h * blk) / 2;
        inh   = (hc >= xs) && (hc < xs + c.w * blk);
        inv   = (vc >= ys) && (vc < ys + c.h * blk);
        q.x   = inh ? (hc - xs) / blk : 0;
        q.y   = inv ? (vc - ys) / blk : 0;
        q.pv  = inh && inv;
        q.act = (hc < c.ha) && (vc < c.va);
        q.hs  = (hc >= c.ha + c.hf && hc < c.ha + c.hf + c.hs) ? c.hpol : !c.hpol;
        q.vs  = (vc >= c.va + c.vf && vc < c.va + c.vf + c.vs) ? c.vpol : !c.vpol;
        q.rgb = q.pv ? img(q.x, q.y) : (q.act ? c.border : 24'h0);
        return q;
    endfunction

    // Expected outputs after mm clock edges since reset release.
    function automatic exp_t model(input cfg_t c, input int mm);
        exp_t e;
        pix_t q;
        int   nt, ht, vt;
        ht     = c.ha + c.hf + c.hs + c.hb;
        vt     = c.va + c.vf + c.vs + c.vb;
        nt     = mm / c.d;
        e.vclk = (mm == 0) ? 1'b0 : (((mm - 1) % c.d) >= c.d / 2);
        e.fs   = ((mm % c.d) == c.d - 1) && ((nt % (ht * vt)) == 0);
        if (nt >= 1) begin
            q    = pix(c, nt - 1);
            e.x  = 10'(q.x);
            e.y  = 9'(q.y);
            e.pv = q.pv;
        end else begin
            e.x  = '0;
            e.y  = '0;
            e.pv = 1'b0;
        end
        if (nt - c.l - 2 >= 0) begin
            q     = pix(c, nt - c.l - 2);
            e.hs  = q.hs;
            e.vs  = q.vs;
            e.bn  = q.act;
            e.rgb = q.rgb;
        end else begin
            e.hs  = !c.hpol;
            e.vs  = !c.vpol;
            e.bn  = 1'b0;
            e.rgb = 24'h0;
        end
        return e;
    endfunction

    // -------------------------------------------------------- colour source
    always @(posedge CLOCK_50) begin
        for (int i = 0; i < 3; i++) begin
            cfg_t c;
            c = get_cfg(i);
            if (!reset && ((m % c.d) == c.d - 1)) begin
                pipe[i][0] <= img(int'(xo[i]), int'(yo[i]));
                for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cfg_t        c;
            logic [23:0] s;
            c = get_cfg(i);
            if (c.l == 0) s = img(int'(xo[i]), int'(yo[i]));
            else          s = pipe[i][c.l-1];
            ri[i] = s[23:16];
            gi[i] = s[15:8];
            bi[i] = s[7:0];
        end
    end

    // ------------------------------------------------------------- checking
    task automatic chk(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s dut%0d m=%0d observed=%0h expected=%0h", tag, i, m, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e = model(get_cfg(i), m);
            chk("x",           i, 32'(xo[i]),  32'(e.x));
            chk("y",           i, 32'(yo[i]),  32'(e.y));
            chk("pix_valid",   i, 32'(pvo[i]), 32'(e.pv));
            chk("frame_start", i, 32'(fso[i]), 32'(e.fs));
            chk("vga_clk",     i, 32'(vco[i]), 32'(e.vclk));
            chk("hs",          i, 32'(hso[i]), 32'(e.hs));
            chk("vs",          i, 32'(vso[i]), 32'(e.vs));
            chk("blank_n",     i, 32'(bno[i]), 32'(e.bn));
            chk("sync_n",      i, 32'(sno[i]), 32'h0);
            chk("rgb",         i, 32'({vro[i], vgo[i], vbo[i]}), 32'(e.rgb));
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            check_all();
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        seed  = $urandom;
        reset = 1'b1;
        // Power-on reset held for 5 cycles: outputs at their idle levels.
        run(5);
        reset = 1'b0;
        // Free run: first tick processes (0,0) and raises frame_start.
        run(9000);
        // Land somewhere mid-line, then reset asynchronously for 5 cycles.
        run($urandom_range(10, 400));
        reset = 1'b1;
        run(5);
        reset = 1'b0;
        // Two full frames of the slowest reduced instance plus wrap.
        run(18000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
